// File: rtl/ped_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ped_pkg : light codes shared with the upstream light FSM, and the
//           pedestrian controller state encoding.
// Rev 1.0
// ----------------------------------------------------------------------------
package ped_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_WALK  = 3'd2,
    S_FLASH = 3'd3,
    S_DONE  = 3'd4
  } ped_state_e;

  // Only the exact red code counts; non-one-hot codes are treated as not red.
  function automatic logic is_red(input logic [2:0] light);
    return light == LIGHT_RED;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ped_down_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ped_down_counter : 4-bit loadable down counter, decrements on enable,
//                    saturates at zero.
// Rev 1.0
// ----------------------------------------------------------------------------
module ped_down_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] count,
  output logic       zero
);

  logic [3:0] r_count;

  // Load wins over decrement so an entry-cycle tick is not charged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 4'd0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign count = r_count;
  assign zero  = (r_count == 4'd0);

endmodule
`default_nettype wire

// File: rtl/ped_walk_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ped_walk_ctrl : pedestrian walk/don't-walk controller slaved to the traffic
//                 light. Define PED_FLASH_EN to enable the flashing phase.
// Rev 1.0
// ----------------------------------------------------------------------------
module ped_walk_ctrl #(
  parameter int WALK_TICKS  = 8,
  parameter int FLASH_TICKS = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] light,
  input  logic       ped_req,
  input  logic       tick,
  output logic       walk,
  output logic       dont_walk,
  output logic       req_pending,
  output logic [3:0] countdown
);

  import ped_pkg::*;

`ifdef PED_FLASH_EN
  localparam ped_state_e c_walk_end = S_FLASH;
`else
  localparam ped_state_e c_walk_end = S_DONE;
`endif

  ped_state_e r_state;
  ped_state_e w_next;
  logic       w_red;
  logic       w_tick_live;
  logic       w_last;
  logic       w_load;
  logic [3:0] w_load_val;
  logic [3:0] w_cnt;
  logic       w_cnt_zero;
  logic       r_walk, r_dont_walk, r_pend;
  logic       w_walk_nxt, w_dont_walk_nxt, w_pend_nxt;
`ifdef PED_FLASH_EN
  logic       r_flash;
  logic       w_flash_nxt;
`endif

  assign w_red       = is_red(light);
  assign w_tick_live = tick && !w_cnt_zero;
  assign w_last      = w_tick_live && (w_cnt == 4'd1);

  // Any state change reloads the counter; idle-type states load zero.
  assign w_load = (w_next != r_state);
  always_comb begin
    w_load_val = 4'd0;
    case (w_next)
      S_WALK:  w_load_val = 4'(WALK_TICKS);
      S_FLASH: w_load_val = 4'(FLASH_TICKS);
      default: w_load_val = 4'd0;
    endcase
  end

  ped_down_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (w_load_val),
    .dec      (tick),
    .count    (w_cnt),
    .zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_walk      <= 1'b0;
      r_dont_walk <= 1'b1;
      r_pend      <= 1'b0;
`ifdef PED_FLASH_EN
      r_flash     <= 1'b1;
`endif
    end else begin
      r_state     <= w_next;
      r_walk      <= w_walk_nxt;
      r_dont_walk <= w_dont_walk_nxt;
      r_pend      <= w_pend_nxt;
`ifdef PED_FLASH_EN
      r_flash     <= w_flash_nxt;
`endif
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (ped_req) w_next = S_WAIT;
      S_WAIT:  if (w_red) w_next = S_WALK;
      S_WALK:  begin
        if (!w_red)      w_next = S_WAIT;
        else if (w_last) w_next = c_walk_end;
      end
      S_FLASH: begin
        if (!w_red)      w_next = S_WAIT;
        else if (w_last) w_next = S_DONE;
      end
      S_DONE:  if (!w_red) w_next = (r_pend || ped_req) ? S_WAIT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_walk_nxt = (w_next == S_WALK);
    case (w_next)
      S_WAIT:  w_pend_nxt = 1'b1;
      S_DONE:  w_pend_nxt = (r_state == S_DONE) && (r_pend || ped_req);
      default: w_pend_nxt = 1'b0;
    endcase
`ifdef PED_FLASH_EN
    // Flash phase starts lit on entry and toggles on each counted tick.
    if (w_next != S_FLASH)       w_flash_nxt = 1'b1;
    else if (r_state != S_FLASH) w_flash_nxt = 1'b1;
    else if (w_tick_live)        w_flash_nxt = ~r_flash;
    else                         w_flash_nxt = r_flash;
    w_dont_walk_nxt = (w_next == S_FLASH) ? w_flash_nxt : (w_next != S_WALK);
`else
    w_dont_walk_nxt = (w_next != S_WALK);
`endif
  end

  assign walk        = r_walk;
  assign dont_walk   = r_dont_walk;
  assign req_pending = r_pend;
  assign countdown   = w_cnt;

endmodule
`default_nettype wire
